// File: rtl/cordic_inputs_if.sv
`default_nettype none
// ------------------------------------------------------------------
// cordic_inputs_if : register-write bus between a host and cordic_inputs
// Rev 1.0
// ------------------------------------------------------------------
interface cordic_inputs_if;
  logic [31:0] bus_data_in;
  logic [1:0]  bus_addr;
  logic        bus_wr;
  logic        bus_ready;

  modport master (output bus_data_in, output bus_addr, output bus_wr, input bus_ready);
  modport slave  (input bus_data_in, input bus_addr, input bus_wr, output bus_ready);
endinterface
`default_nettype wire

// File: rtl/cordic_inputs.sv
`default_nettype none
// ------------------------------------------------------------------
// cordic_inputs : operand staging, range-checked command queue and launch FSM for a CORDIC core
// Rev 1.0
// ------------------------------------------------------------------
module cordic_inputs #(
  parameter int QDEPTH  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  cordic_inputs_if.slave     bus,
  output logic signed [31:0] core_x0,
  output logic signed [31:0] core_y0,
  output logic signed [31:0] core_z0,
  output logic               core_start,
  input  logic               core_done,
  output logic               busy,
  output logic [1:0]         err,
  output logic [15:0]        done_count
);
  localparam int AW = $clog2(QDEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]          c_QDEPTH = (AW+1)'(QDEPTH);
  localparam logic [TW-1:0]        c_TLAST  = TW'(TIMEOUT - 1);
  localparam logic signed [31:0]   c_ZMAX   = 32'sh3243F6A8;
  localparam logic signed [31:0]   c_ZMIN   = -32'sh3243F6A8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_e;

  state_e             state_q;
  logic signed [31:0] sx_q, sy_q, sz_q;
  logic signed [31:0] qx_q [QDEPTH];
  logic signed [31:0] qy_q [QDEPTH];
  logic signed [31:0] qz_q [QDEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q;
  logic [TW-1:0]      tmo_q;
  logic [1:0]         err_q, err_d;
  logic [15:0]        done_count_q;
  logic signed [31:0] x_q, y_q, z_q;
  logic               start_q;

  logic ready, wr_acc, ctrl_wr, go, clr, z_ok, push, pop, tmo_hit;

  assign ready   = (count_q < c_QDEPTH);
  assign wr_acc  = bus.bus_wr && ready;
  assign ctrl_wr = wr_acc && (bus.bus_addr == 2'd3);
  assign go      = ctrl_wr && bus.bus_data_in[0];
  assign clr     = ctrl_wr && bus.bus_data_in[1];
  assign z_ok    = (sz_q >= c_ZMIN) && (sz_q <= c_ZMAX);
  assign push    = go && z_ok;
  assign pop     = (state_q == S_IDLE) && (count_q != '0);
  assign tmo_hit = (state_q == S_WAIT) && !core_done && (tmo_q == c_TLAST);

  // Clear is applied before the go check so a rejected go in the same write stays flagged.
  always_comb begin
    err_d = err_q;
    if (clr)        err_d    = 2'b00;
    if (go && !z_ok) err_d[0] = 1'b1;
    if (tmo_hit)    err_d[1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sx_q     <= '0;
      sy_q     <= '0;
      sz_q     <= '0;
      err_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_acc) begin
        case (bus.bus_addr)
          2'd0:    sx_q <= bus.bus_data_in;
          2'd1:    sy_q <= bus.bus_data_in;
          2'd2:    sz_q <= bus.bus_data_in;
          default: ;
        endcase
      end
      err_q <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Queue storage needs no reset: entries are only read while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      qx_q[wr_ptr_q] <= sx_q;
      qy_q[wr_ptr_q] <= sy_q;
      qz_q[wr_ptr_q] <= sz_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      tmo_q        <= '0;
      done_count_q <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            x_q     <= qx_q[rd_ptr_q];
            y_q     <= qy_q[rd_ptr_q];
            z_q     <= qz_q[rd_ptr_q];
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          start_q <= 1'b1;
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            done_count_q <= done_count_q + 16'd1;
            state_q      <= S_IDLE;
          end else if (tmo_hit) begin
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.bus_ready = ready;
  assign core_x0       = x_q;
  assign core_y0       = y_q;
  assign core_z0       = z_q;
  assign core_start    = start_q;
  assign busy          = (state_q != S_IDLE) || (count_q != '0);
  assign err           = err_q;
  assign done_count    = done_count_q;
endmodule
`default_nettype wire

// File: tb/tb_cordic_inputs.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_cordic_inputs : directed scenarios plus randomized command traffic against a job-level model
// Rev 1.0
// ------------------------------------------------------------------
module tb_cordic_inputs;
  localparam int     QDEPTH  = 2;
  localparam int     TIMEOUT = 64;
  localparam longint c_PI2   = 64'sh3243F6A8;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    int          cyc;
  } start_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               core_done = 1'b0;
  logic signed [31:0] core_x0, core_y0, core_z0;
  logic               core_start, busy;
  logic [1:0]         err;
  logic [15:0]        done_count;

  cordic_inputs_if bif ();

  cordic_inputs #(.QDEPTH(QDEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bif),
    .core_x0    (core_x0),
    .core_y0    (core_y0),
    .core_z0    (core_z0),
    .core_start (core_start),
    .core_done  (core_done),
    .busy       (busy),
    .err        (err),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Every launch pulse is logged with its operands and the edge number that raised it.
  start_t st_q[$];
  always begin
    @(posedge clk); #2;
    if (core_start === 1'b1) st_q.push_back('{x: core_x0, y: core_y0, z: core_z0, cyc: cyc});
  end

  // Core stand-in: manual one-shot pulses on request, or automatic completion after a random delay.
  logic auto_done = 1'b0;
  int   req_cnt = 0;
  int   ack_cnt = 0;
  int   dly;
  always begin
    @(posedge clk); #3;
    core_done = 1'b0;
    if (req_cnt != ack_cnt) begin
      core_done = 1'b1;
      ack_cnt++;
    end else if (auto_done && core_start === 1'b1) begin
      dly = $urandom_range(0, 8);
      repeat (dly) begin @(posedge clk); #3; end
      core_done = 1'b1;
    end
  end

  // Job-level model: staging values, sticky errors, expected launches and completion count.
  logic [31:0] m_sx = '0, m_sy = '0, m_sz = '0;
  logic [1:0]  m_err = '0;
  logic [15:0] exp_done = '0;
  logic [95:0] exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic bit z_in_range(input logic [31:0] z);
    longint v;
    v = longint'($signed(z));
    return (v >= -c_PI2) && (v <= c_PI2);
  endfunction

  task automatic model_apply(input logic [1:0] a, input logic [31:0] d);
    case (a)
      2'd0: m_sx = d;
      2'd1: m_sy = d;
      2'd2: m_sz = d;
      default: begin
        if (d[1]) m_err = 2'b00;
        if (d[0]) begin
          if (z_in_range(m_sz)) exp_q.push_back({m_sx, m_sy, m_sz});
          else                  m_err[0] = 1'b1;
        end
      end
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    bif.bus_wr = 1'b0;
  endtask

  int last_edge = 0;
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic exp_rdy);
    @(negedge clk);
    bif.bus_wr      = 1'b1;
    bif.bus_addr    = a;
    bif.bus_data_in = d;
    check("bus_ready_at_write", 64'(bif.bus_ready), 64'(exp_rdy));
    if (exp_rdy) model_apply(a, d);
    last_edge = cyc + 1;
  endtask

  task automatic expect_launches(input bit count_done);
    int n;
    start_t s;
    logic [95:0] e;
    n = 0;
    tick();
    while ((st_q.size() < exp_q.size() || busy !== 1'b0) && n < 300) begin
      tick();
      n++;
    end
    check("drain_in_time", 64'(n < 300), 64'(1));
    check("launch_count", 64'(st_q.size()), 64'(exp_q.size()));
    while (st_q.size() != 0 && exp_q.size() != 0) begin
      s = st_q.pop_front();
      e = exp_q.pop_front();
      check("core_x0", 64'(s.x), 64'(e[95:64]));
      check("core_y0", 64'(s.y), 64'(e[63:32]));
      check("core_z0", 64'(s.z), 64'(e[31:0]));
      if (count_done) exp_done = exp_done + 16'd1;
    end
    st_q.delete();
    exp_q.delete();
    check("done_count", 64'(done_count), 64'(exp_done));
    check("err", 64'(err), 64'(m_err));
    check("bus_ready_idle", 64'(bif.bus_ready), 64'(1));
  endtask

  int          n;
  int          e_go;
  logic [31:0] rz, rc;

  initial begin
    bif.bus_wr      = 1'b0;
    bif.bus_addr    = 2'd0;
    bif.bus_data_in = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_bus_ready", 64'(bif.bus_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_done_count", 64'(done_count), 64'(0));
    check("rst_core_start", 64'(core_start), 64'(0));
    check("rst_operands", 64'({core_x0, core_y0} | 64'(core_z0)), 64'(0));
    rst = 1'b0;

    // First job: launch latency and operand values
    bus_write(2'd0, 32'h2000_0000, 1'b1);
    bus_write(2'd1, 32'h0000_0000, 1'b1);
    bus_write(2'd2, 32'h1000_0000, 1'b1);
    bus_write(2'd3, 32'h0000_0001, 1'b1);
    e_go = last_edge;
    n = 0;
    while (st_q.size() == 0 && n < 10) begin tick(); n++; end
    check("start_seen", 64'(st_q.size()), 64'(1));
    if (st_q.size() != 0) check("start_latency", 64'(st_q[0].cyc), 64'(e_go + 2));
    check("busy_in_job", 64'(busy), 64'(1));
    req_cnt++;
    expect_launches(1'b1);

    // Completion pulse while idle is ignored
    req_cnt++;
    repeat (3) tick();
    check("idle_done_ignored", 64'(done_count), 64'(exp_done));

    // Queue fills: one in flight plus two queued blocks the bus
    bus_write(2'd0, 32'h1111_1111, 1'b1);
    bus_write(2'd3, 32'h0000_0001, 1'b1);
    bus_write(2'd3, 32'h0000_0001, 1'b1);
    bus_write(2'd3, 32'h0000_0001, 1'b1);
    bus_write(2'd0, 32'hDEAD_BEEF, 1'b0);
    tick();
    check("bus_ready_full", 64'(bif.bus_ready), 64'(0));
    check("one_in_flight", 64'(st_q.size()), 64'(1));
    req_cnt++;
    repeat (6) tick();
    check("bus_ready_after_done", 64'(bif.bus_ready), 64'(1));
    check("second_launched", 64'(st_q.size()), 64'(2));
    req_cnt++;
    repeat (6) tick();
    req_cnt++;
    expect_launches(1'b1);

    // Timeout: no completion ever arrives
    bus_write(2'd3, 32'h0000_0001, 1'b1);
    e_go = last_edge;
    while (cyc < e_go + TIMEOUT + 1) tick();
    check("err_before_timeout", 64'(err), 64'(m_err));
    check("busy_before_timeout", 64'(busy), 64'(1));
    tick();
    m_err[1] = 1'b1;
    check("err_at_timeout", 64'(err), 64'(m_err));
    check("busy_after_timeout", 64'(busy), 64'(0));
    expect_launches(1'b0);
    bus_write(2'd3, 32'h0000_0002, 1'b1);
    expect_launches(1'b1);

    // Range rejects, clear, and the pi/2 boundaries
    auto_done = 1'b1;
    bus_write(2'd2, 32'h4000_0000, 1'b1);
    bus_write(2'd3, 32'h0000_0001, 1'b1);
    expect_launches(1'b1);
    bus_write(2'd3, 32'h0000_0002, 1'b1);
    expect_launches(1'b1);
    bus_write(2'd3, 32'h0000_0003, 1'b1);
    expect_launches(1'b1);
    bus_write(2'd3, 32'h0000_0002, 1'b1);
    expect_launches(1'b1);
    bus_write(2'd2, 32'h3243_F6A8, 1'b1);
    bus_write(2'd3, 32'h0000_0001, 1'b1);
    expect_launches(1'b1);
    bus_write(2'd2, 32'hCDBC_0958, 1'b1);
    bus_write(2'd3, 32'h0000_0001, 1'b1);
    expect_launches(1'b1);
    bus_write(2'd2, 32'h3243_F6A9, 1'b1);
    bus_write(2'd3, 32'h0000_0001, 1'b1);
    expect_launches(1'b1);
    bus_write(2'd2, 32'hCDBC_0957, 1'b1);
    bus_write(2'd3, 32'h0000_0003, 1'b1);
    expect_launches(1'b1);
    bus_write(2'd3, 32'h0000_0002, 1'b1);
    expect_launches(1'b1);

    // Completion counter wraps
    force dut.done_count_q = 16'hFFFE;
    tick();
    release dut.done_count_q;
    exp_done = 16'hFFFE;
    tick();
    check("done_count_preload", 64'(done_count), 64'(16'hFFFE));
    bus_write(2'd2, 32'h0000_1000, 1'b1);
    bus_write(2'd3, 32'h0000_0001, 1'b1);
    expect_launches(1'b1);
    bus_write(2'd3, 32'h0000_0001, 1'b1);
    expect_launches(1'b1);
    check("done_count_wrap", 64'(done_count), 64'(16'h0000));

    // Randomized command traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) bus_write(2'd0, $urandom, 1'b1);
      if ($urandom_range(0, 1) == 1) bus_write(2'd1, $urandom, 1'b1);
      case ($urandom_range(0, 3))
        0: rz = $urandom;
        1: rz = 32'($urandom_range(0, 32'h3243F6A8));
        2: rz = -32'($urandom_range(0, 32'h3243F6A8));
        default: begin
          rc = $urandom_range(0, 3);
          rz = (rc == 0) ? 32'h3243_F6A8 : (rc == 1) ? 32'hCDBC_0958 :
               (rc == 2) ? 32'h3243_F6A9 : 32'hCDBC_0957;
        end
      endcase
      bus_write(2'd2, rz, 1'b1);
      rc    = $urandom;
      rc[0] = ($urandom_range(0, 3) != 0);
      rc[1] = ($urandom_range(0, 3) == 0);
      bus_write(2'd3, rc, 1'b1);
      expect_launches(1'b1);
    end

    // Reset during WAIT with two jobs queued
    auto_done = 1'b0;
    bus_write(2'd2, 32'h0000_0100, 1'b1);
    bus_write(2'd3, 32'h0000_0001, 1'b1);
    bus_write(2'd3, 32'h0000_0001, 1'b1);
    bus_write(2'd3, 32'h0000_0001, 1'b1);
    repeat (3) tick();
    check("busy_before_rst", 64'(busy), 64'(1));
    rst = 1'b1;
    st_q.delete();
    exp_q.delete();
    m_sx = '0; m_sy = '0; m_sz = '0; m_err = '0; exp_done = '0;
    repeat (2) tick();
    check("midrst_bus_ready", 64'(bif.bus_ready), 64'(1));
    check("midrst_operands", 64'({core_x0, core_y0} | 64'(core_z0)), 64'(0));
    check("midrst_done_count", 64'(done_count), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("busy_after_rst", 64'(busy), 64'(0));
    end
    check("no_start_after_rst", 64'(st_q.size()), 64'(0));
    auto_done = 1'b1;
    bus_write(2'd3, 32'h0000_0001, 1'b1);
    expect_launches(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
